// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - opcode constants and immediate helpers shared by fetch and decode
package inst_fetch_pkg;

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    // J-type immediate from instruction bits [31:12], sign-extended to 32 bits
    function automatic logic [31:0] j_imm(input logic [19:0] hi);
        return {{11{hi[19]}}, hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - synchronous {pc,inst} buffer with push/pop/flush and occupancy count
module inst_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointer and occupancy bookkeeping; flush wins over any push/pop in the same cycle
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage array has no reset; entries are only read once counted as valid
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: PC owner, imem req/ack, JAL predecode, redirect, output register
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] PC_o,
    output logic        inst_valid
);

    import inst_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // DRAIN means a request is still outstanding but its data belongs to a stale path
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic          redirect;
    logic [31:0]   redir_target;
    logic          acked;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [31:0]   next_pc;
    logic [63:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    assign redirect     = branch_taken | jalr_en;
    assign redir_target = (branch_taken ? branch_target : jalr_target) & 32'hFFFF_FFFC;

    // Only one request may be in flight; in IDLE nothing is, so credit is FIFO space alone
    assign credit_ok = (fifo_count < CW'(FIFO_DEPTH));
    assign acked     = (state == S_REQ) && imem_ack;
    assign push      = acked && !redirect && (!fifo_full || pop);
    assign pop       = !redirect && !stall && !fifo_empty;

    // Predecoded JAL steers the next fetch without waiting for execute
    assign next_pc = (imem_rdata[6:0] == OP_JAL) ? imem_addr + j_imm(imem_rdata[31:12])
                                                 : imem_addr + 32'd4;

    inst_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push      (push),
        .push_data ({imem_addr, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Request FSM: req/addr stay frozen from issue until the ack, even across a redirect
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!redirect && credit_ok) begin
                        state     <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end else if (redirect) begin
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Fetch PC: redirects override the sequential/JAL successor of an accepted word
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redir_target;
        end else if (push) begin
            fetch_pc <= next_pc;
        end
    end

    // Decode-facing register: redirect forces a bubble even under stall
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            inst       <= NOP_INST;
            PC_o       <= RESET_PC;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (!stall) begin
            if (!fifo_empty) begin
                inst       <= fifo_head[31:0];
                PC_o       <= fifo_head[63:32];
                inst_valid <= 1'b1;
            end else begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        CLK = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jalr_en;
    logic [31:0] jalr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] PC_o;
    logic        inst_valid;

    int n_cmp   = 0;
    int n_fail  = 0;
    int mem_lat = 1;
    int wait_cnt = 0;
    bit saw_14  = 1'b0;

    inst_fetch dut (
        .CLK           (CLK),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jalr_en       (jalr_en),
        .jalr_target   (jalr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst          (inst),
        .PC_o          (PC_o),
        .inst_valid    (inst_valid)
    );

    always #5 CLK = ~CLK;

    // Memory image: JAL +0x20 at 0x10, otherwise addi x1 with the address in the upper bits
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0200_006F;
        return {a[19:0], 12'h093};
    endfunction

    // Instruction memory responder: acks mem_lat negedges after seeing a request
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge CLK);
            imem_ack = 1'b0;
            if (!reset) begin
                wait_cnt = 0;
            end else if (imem_req) begin
                if (imem_addr == 32'h14) saw_14 = 1'b1;
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_cnt   = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] epc, input logic [31:0] einst);
        int k = 0;
        do begin
            step();
            k++;
        end while (inst_valid !== 1'b1 && k < 40);
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_pc"}, PC_o, epc);
        check({tag, "_inst"}, inst, einst);
    endtask

    initial begin
        int k;
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jalr_en       = 1'b0;
        jalr_target   = 32'h0;
        repeat (3) step();

        check("rst_inst",  inst, 32'h0000_0013);
        check("rst_pc",    PC_o, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);

        reset = 1'b1;
        wait_valid("seq0", 32'h00, 32'h0000_0093);
        wait_valid("seq4", 32'h04, 32'h0000_4093);
        wait_valid("seq8", 32'h08, 32'h0000_8093);
        wait_valid("seqc", 32'h0C, 32'h0000_C093);
        wait_valid("jal",  32'h10, 32'h0200_006F);
        wait_valid("jal_tgt", 32'h30, 32'h0003_0093);
        check("no_req_14", 32'(saw_14), 32'd0);

        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_pc",    PC_o, 32'h30);
            check("stall_valid", 32'(inst_valid), 32'd1);
        end
        check("stall_req_low", 32'(imem_req), 32'd0);
        stall = 1'b0;
        wait_valid("res34", 32'h34, 32'h0003_4093);
        wait_valid("res38", 32'h38, 32'h0003_8093);
        wait_valid("res3c", 32'h3C, 32'h0003_C093);

        mem_lat = 3;
        reset = 1'b0;
        step();
        reset = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!(imem_req === 1'b1 && imem_addr === 32'h8) && k < 60);
        check("br_pend_addr", imem_addr, 32'h8);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken  = 1'b0;
        check("br_nop_valid", 32'(inst_valid), 32'd0);
        check("br_nop_inst",  inst, 32'h0000_0013);
        check("br_hold_req",  32'(imem_req), 32'd1);
        check("br_hold_addr", imem_addr, 32'h8);
        k = 0;
        do begin
            step();
            k++;
        end while (!(imem_req === 1'b1 && imem_addr !== 32'h8) && k < 60);
        check("br_new_addr", imem_addr, 32'h100);
        wait_valid("br_tgt", 32'h100, 32'h0010_0093);

        branch_taken  = 1'b1;
        branch_target = 32'h200;
        jalr_en       = 1'b1;
        jalr_target   = 32'h300;
        step();
        branch_taken  = 1'b0;
        jalr_en       = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (!(imem_req === 1'b1 && (imem_addr === 32'h200 || imem_addr === 32'h300)) && k < 60);
        check("dual_addr", imem_addr, 32'h200);
        wait_valid("dual_tgt", 32'h200, 32'h0020_0093);

        jalr_en     = 1'b1;
        jalr_target = 32'h402;
        step();
        jalr_en     = 1'b0;
        wait_valid("jalr_tgt", 32'h400, 32'h0040_0093);

        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken  = 1'b0;
        wait_valid("wrap_hi", 32'hFFFF_FFFC, 32'hFFFF_C093);
        wait_valid("wrap_lo", 32'h0, 32'h0000_0093);

        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("mid_req_seen", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_req",   32'(imem_req), 32'd0);
        check("mid_rst_addr",  imem_addr, 32'h0);
        check("mid_rst_inst",  inst, 32'h0000_0013);
        check("mid_rst_pc",    PC_o, 32'h0);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        step();
        reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
